sr_request_conditioner: RTL
===========================

// Module: sr_request_conditioner
// PURPOSE
//  Upstream stage of the SR flip-flop (built on a JK cell, so s=r=1 toggles).
//  Takes two raw, asynchronous set/clear request lines (buttons, external pins).
//  Synchronises and debounces each line, then detects its rising edge.
//  Arbitrates the two lines and emits single-cycle s / r pulses.
//  Guarantees s and r are never high together, so the downstream flop never toggles.
// PARAMETERS
//  DEBOUNCE_CYCLES  4  consecutive stable synced cycles before debounced level changes (>=1)
//  DB_CNT_W         3  width of per-channel debounce counter (must hold DEBOUNCE_CYCLES)
//  HOLDOFF_CYCLES   2  dead cycles after each pulse; 0 = return to IDLE directly
//  PRIORITY_RESET   1  on a same-cycle conflict: 1 = r wins, 0 = s wins
// PORTS
//  clock        in   1  single system clock, rising edge
//  rst          in   1  asynchronous, active-low reset
//  set_req_raw  in   1  raw set request, asynchronous to clock
//  clr_req_raw  in   1  raw clear request, asynchronous to clock
//  s            out  1  one-cycle set pulse to SR flop s input, registered
//  r            out  1  one-cycle reset pulse to SR flop r input, registered
//  busy         out  1  high while in PULSE or HOLDOFF
//  drop_cnt     out  8  saturating count of discarded request events
// BEHAVIOUR
//  Reset (rst=0, asynchronous)
//   - Clears all state: sync flops, debounced levels, counters, FSM=IDLE.
//   - Outputs: s=0, r=0, busy=0, drop_cnt=0.
//   - Reset asserted mid-pulse kills the pulse immediately.
//  Sync: 2-flop synchroniser per channel, reset value 0.
//  Debounce (per channel)
//   - Counter increments while synced != debounced level; clears when they match.
//   - Debounced level flips when counter reaches DEBOUNCE_CYCLES; counter then clears.
//   - Glitches shorter than DEBOUNCE_CYCLES never change the level.
//  Edge detect: event = debounced rising edge (1 cycle). Falling edges: no event.
//   - Input already high at reset release produces one event after debounce.
//  FSM states and transitions
//   - IDLE: wait for an event.
//   - IDLE -> PULSE on any event.
//     - Both events same cycle: PRIORITY_RESET picks the winner.
//     - Loser event is dropped; drop_cnt += 1.
//   - PULSE lasts exactly 1 cycle, with s or r = 1 for the winning event.
//   - PULSE -> HOLDOFF for HOLDOFF_CYCLES cycles, then -> IDLE.
//     - If HOLDOFF_CYCLES = 0: PULSE -> IDLE.
//   - Events arriving in PULSE or HOLDOFF are dropped (not queued); drop_cnt += 1 each.
//   - Two events in one cycle during busy: drop_cnt += 2.
//   - drop_cnt saturates at 255 and stays there.
//  Latency: raw rise sampled at edge k -> s or r high after edge k+3+DEBOUNCE_CYCLES.
//   - Default: k+7.
//  Invariants: s & r == 0 always; at most one pulse per 1+HOLDOFF_CYCLES cycles.
// STRUCTURE
//  Shared package sr_cond_pkg:
//   - FSM state encoding: IDLE=2'd0, PULSE=2'd1, HOLDOFF=2'd2.
//   - DROP_CNT_W=8.
//   - Default parameter constants.
//  Sub-module sr_debounce_chan (synchroniser + debounce + rising-edge detect):
//   - Instantiated once per channel; outputs a 1-cycle evt.
//  Top level: arbiter/FSM, holdoff counter, drop counter.
// TESTING
//  T1 Latency: set_req_raw 0->1, held 20 cycles -> exactly one s pulse at edge k+7;
//     r=0; busy high for 3 cycles.
//  T2 Glitch reject: clr_req_raw high for 3 cycles, then low -> no r pulse;
//     drop_cnt=0.
//  T3 Conflict: both raw inputs rise on the same edge, PRIORITY_RESET=1 -> one r pulse,
//     no s; drop_cnt=1. Repeat with PRIORITY_RESET=0 -> s pulse.
//  T4 Holdoff drop: clr event lands 1 cycle after s pulse -> no r pulse; drop_cnt=1.
//     Clr event 3 cycles after s pulse -> r pulse.
//  T5 Reset mid-op: rst=0 during PULSE -> s=0 at once, busy=0, drop_cnt=0.
//     set_req_raw held high through rst release -> one s pulse 7 cycles later.
//  T6 Saturation plus invariant: 300 forced drops -> drop_cnt=255.
//     Assertion !(s&&r) holds for the whole run.

Source files
------------

// File: rtl/sr_cond_pkg.sv
// rtl/sr_cond_pkg.sv - shared types, widths and defaults for the set/clear request conditioner
package sr_cond_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PULSE   = 2'd1,
      HOLDOFF = 2'd2
   } state_t;

   localparam int DROP_CNT_W          = 8;
   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_DB_CNT_W        = 3;
   localparam int DEF_HOLDOFF_CYCLES  = 2;
   localparam int DEF_PRIORITY_RESET  = 1;

   // Drop counter add that sticks at all-ones instead of wrapping.
   function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] cnt,
                                                     input logic [1:0] inc);
      logic [DROP_CNT_W:0] sum;
      sum = {1'b0, cnt} + {{(DROP_CNT_W-1){1'b0}}, inc};
      return sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : sum[DROP_CNT_W-1:0];
   endfunction

endpackage

// File: rtl/sr_debounce_chan.sv
// rtl/sr_debounce_chan.sv - per-channel 2-flop synchroniser, debounce filter and rising-edge event
module sr_debounce_chan
   import sr_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int DB_CNT_W        = DEF_DB_CNT_W
) (
   input  logic clock,
   input  logic rst,
   input  logic req_raw,
   output logic evt
);

   localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_CNT_W-1:0] CNT_ONE  = DB_CNT_W'(1);

   logic                sync1;
   logic                sync2;
   logic                level;
   logic                level_d;
   logic [DB_CNT_W-1:0] cnt;

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
         evt     <= 1'b0;
      end else begin
         sync1   <= req_raw;
         sync2   <= sync1;
         level_d <= level;
         evt     <= level & ~level_d;
         // The Nth consecutive disagreeing sample commits the new level.
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/sr_request_conditioner.sv
// rtl/sr_request_conditioner.sv - arbitrates debounced set/clear events into exclusive s/r pulses
module sr_request_conditioner
   import sr_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int DB_CNT_W        = DEF_DB_CNT_W,
   parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
   parameter int PRIORITY_RESET  = DEF_PRIORITY_RESET
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  set_req_raw,
   input  logic                  clr_req_raw,
   output logic                  s,
   output logic                  r,
   output logic                  busy,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   localparam int HO_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
   localparam logic [HO_W-1:0] HO_ONE = HO_W'(1);

   logic            set_evt;
   logic            clr_evt;
   logic [1:0]      evt_count;
   state_t          state;
   logic [HO_W-1:0] hold_cnt;

   sr_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_CNT_W       (DB_CNT_W)
   ) u_set_chan (
      .clock  (clock),
      .rst    (rst),
      .req_raw(set_req_raw),
      .evt    (set_evt)
   );

   sr_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_CNT_W       (DB_CNT_W)
   ) u_clr_chan (
      .clock  (clock),
      .rst    (rst),
      .req_raw(clr_req_raw),
      .evt    (clr_evt)
   );

   assign evt_count = {1'b0, set_evt} + {1'b0, clr_evt};

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         hold_cnt <= '0;
         s        <= 1'b0;
         r        <= 1'b0;
         busy     <= 1'b0;
         drop_cnt <= '0;
      end else begin
         s <= 1'b0;
         r <= 1'b0;
         case (state)
            IDLE: begin
               if (set_evt || clr_evt) begin
                  state <= PULSE;
                  busy  <= 1'b1;
                  if (set_evt && clr_evt) begin
                     // Only one side may fire so the JK-based flop never toggles.
                     if (PRIORITY_RESET != 0) r <= 1'b1;
                     else                     s <= 1'b1;
                     drop_cnt <= sat_add(drop_cnt, 2'd1);
                  end else begin
                     s <= set_evt;
                     r <= clr_evt;
                  end
               end
            end
            PULSE: begin
               drop_cnt <= sat_add(drop_cnt, evt_count);
               if (HOLDOFF_CYCLES == 0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  state    <= HOLDOFF;
                  hold_cnt <= HO_W'(HOLDOFF_CYCLES - 1);
               end
            end
            HOLDOFF: begin
               drop_cnt <= sat_add(drop_cnt, evt_count);
               if (hold_cnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt - HO_ONE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
